// File: rtl/cues_tok_pkg.sv
// cues_tok_pkg: token field widths, the packed token record and the FC1 handshake FSM states
package cues_tok_pkg;
    localparam int NODE_W   = 16;
    localparam int GEN_W    = 12;
    localparam int OPR_W    = 32;
    localparam int MEMWEN_W = 2;
    localparam int TOK_W    = NODE_W + GEN_W + 2 * OPR_W + MEMWEN_W;
    typedef struct packed {
        logic [NODE_W-1:0]   node;
        logic [GEN_W-1:0]    gen;
        logic [OPR_W-1:0]    opr0;
        logic [OPR_W-1:0]    opr1;
        logic [MEMWEN_W-1:0] mem_wen;
    } token_t;
    typedef enum logic [1:0] {IDLE, REQ, REL} fc1_state_t;
endpackage

// File: rtl/ack_sync.sv
// ack_sync: SYNC_STAGES-deep flop chain bringing the asynchronous merge acknowledge into clk
//   clk     in  clock
//   rst     in  asynchronous active-low reset, chain clears to 0
//   ack_i   in  asynchronous acknowledge
//   ack_s_o out synchronized acknowledge
module ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ack_i,
    output logic ack_s_o
);
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], ack_i};
    end
    assign ack_s_o = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/fc1_token_fifo.sv
// fc1_token_fifo: token FIFO feeding the merge stage FC1 port over a 4-phase send/ack handshake
//   clk, rst (async active-low)
//   push_valid_i/push_ready_o + node_i/gen_i/opr0_i/opr1_i/mem_wen_i : valid/ready token push
//   send_o/ack_i + node_o/gen_o/opr0_o/opr1_o/mem_wen_o : 4-phase token delivery (ack_i async)
//   afull_o : occupancy >= AFULL_THRESH
//   level_o : occupancy, present only when FC1_FIFO_LEVEL_EN is defined
module fc1_token_fifo
    import cues_tok_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid_i,
    output logic                 push_ready_o,
    input  logic [NODE_W-1:0]    node_i,
    input  logic [GEN_W-1:0]     gen_i,
    input  logic [OPR_W-1:0]     opr0_i,
    input  logic [OPR_W-1:0]     opr1_i,
    input  logic [MEMWEN_W-1:0]  mem_wen_i,
    output logic                 send_o,
    input  logic                 ack_i,
    output logic [NODE_W-1:0]    node_o,
    output logic [GEN_W-1:0]     gen_o,
    output logic [OPR_W-1:0]     opr0_o,
    output logic [OPR_W-1:0]     opr1_o,
    output logic [MEMWEN_W-1:0]  mem_wen_o,
    output logic                 afull_o
`ifdef FC1_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    token_t           r_mem [DEPTH];
    token_t           r_tok;
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_ready, r_afull;
    fc1_state_t       r_state, w_state_nxt;
    logic             w_ack_s, w_push, w_pop, w_load, w_empty, w_full_nxt;

    ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk     (clk),
        .rst     (rst),
        .ack_i   (ack_i),
        .ack_s_o (w_ack_s)
    );

    assign w_empty     = r_wr_ptr == r_rd_ptr;
    assign w_push      = push_valid_i && r_ready;
    assign w_wr_nxt    = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    assign w_rd_nxt    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    // full: same slot index, opposite wrap bit
    assign w_full_nxt  = w_wr_nxt == {~w_rd_nxt[PTR_W-1], w_rd_nxt[IDX_W-1:0]};
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= {node_i, gen_i, opr0_i, opr1_i, mem_wen_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_afull  <= 1'b0;
            r_tok    <= '0;
            r_state  <= IDLE;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_ready  <= !w_full_nxt;
            r_afull  <= w_count_nxt >= CNT_W'(AFULL_THRESH);
            r_state  <= w_state_nxt;
            if (w_load) r_tok <= r_mem[r_rd_ptr[IDX_W-1:0]];
        end
    end

    // head is only consumed once the merge stage acknowledges it, so the output register
    // doubles as the presented copy while the entry stays counted until the pop
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: if (!w_empty && !w_ack_s) begin
                w_load      = 1'b1;
                w_state_nxt = REQ;
            end
            REQ: if (w_ack_s) begin
                w_pop       = 1'b1;
                w_state_nxt = REL;
            end
            REL: if (!w_ack_s) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign send_o       = r_state == REQ;
    assign push_ready_o = r_ready;
    assign afull_o      = r_afull;
    assign node_o       = r_tok.node;
    assign gen_o        = r_tok.gen;
    assign opr0_o       = r_tok.opr0;
    assign opr1_o       = r_tok.opr1;
    assign mem_wen_o    = r_tok.mem_wen;
`ifdef FC1_FIFO_LEVEL_EN
    assign level_o      = r_count;
`endif
endmodule
